// File: rtl/audio_mix_scheduler_pkg.sv
// Shared audio package (audio_pkg) used by the mix scheduler slice.
// Contents:
//   PCM_W          sample width of one stereo side
//   AUDIO_SILENCE  unsigned PCM mid-scale code (silence)
//   audio_frame_t  packed stereo frame, r in [31:16], l in [15:0]
//   mix_state_t    scheduler FSM states
//   pcm_to_signed  offset-binary PCM to two's-complement conversion
package audio_pkg;

  localparam int PCM_W = 16;
  localparam logic [PCM_W-1:0] AUDIO_SILENCE = 16'h8000;

  typedef struct packed {
    logic [PCM_W-1:0] r;
    logic [PCM_W-1:0] l;
  } audio_frame_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATHER = 3'd1,
    SCALE  = 3'd2,
    PUSH   = 3'd3,
    HOLD   = 3'd4
  } mix_state_t;

  // Flipping the MSB turns offset-binary PCM into two's complement and back.
  function automatic logic signed [PCM_W-1:0] pcm_to_signed(input logic [PCM_W-1:0] pcm);
    return $signed(pcm ^ AUDIO_SILENCE);
  endfunction

endpackage

// File: rtl/audio_mix_scheduler_if.sv
// Push interface between the mix scheduler and the audio_output sink.
// Signals:
//   out_data          32-bit stereo frame {R, L}, unsigned PCM
//   out_valid_toggle  flips once per pushed frame
//   out_full          sink back-pressure, sampled only between frames
// Modports: master (scheduler side), slave (sink side).
interface audio_mix_scheduler_if;
  import audio_pkg::*;

  logic [2*PCM_W-1:0] out_data;
  logic               out_valid_toggle;
  logic               out_full;

  modport master (
    output out_data,
    output out_valid_toggle,
    input  out_full
  );

  modport slave (
    input  out_data,
    input  out_valid_toggle,
    output out_full
  );

endinterface

// File: rtl/audio_mix_scheduler_limit.sv
// audio_mix_limit: attenuates a signed mix accumulator and converts it to
// unsigned 16-bit PCM.
// Ports:
//   acc    in   ACC_W  signed accumulator
//   shift  in   3      arithmetic right shift (0..7)
//   pcm    out  16     unsigned PCM result
// Build option: AUDIO_MIX_SATURATE_EN clamps to [-32768, 32767]; without it
// the low 16 bits are kept (two's-complement wrap) and no clamp is built.
module audio_mix_limit
  import audio_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [2:0]       shift,
  output logic        [PCM_W-1:0] pcm
);

  logic signed [PCM_W-1:0] lim_s;

`ifdef AUDIO_MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(-32'sd32768);

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = acc >>> shift;

  // Clamp the attenuated sum into the signed 16-bit range.
  always_comb begin
    lim_s = shifted_s[PCM_W-1:0];
    if (shifted_s > MAX_S) begin
      lim_s = 16'sh7FFF;
    end else if (shifted_s < MIN_S) begin
      lim_s = 16'sh8000;
    end else begin
      lim_s = shifted_s[PCM_W-1:0];
    end
  end
`else
  assign lim_s = PCM_W'(acc >>> shift);
`endif

  assign pcm = lim_s ^ AUDIO_SILENCE;

endmodule

// File: rtl/audio_mix_scheduler.sv
// audio_mix_scheduler: polls NUM_CH stereo sources once per output frame,
// mixes the consumed samples and pushes one frame to audio_output.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ch_data           per-channel {R, L} frames, unsigned PCM
//   ch_valid/ready    per-channel handshake (ready is combinational in GATHER)
//   ch_enable         channel participates in the mix
//   atten_shift       arithmetic right shift applied to the mixed sum
//   out_if            push interface (data / valid_toggle / full)
//   underrun_count    enabled channels found not valid when polled, saturating
//   busy              FSM not in IDLE
// Build option: AUDIO_MIX_SATURATE_EN selects clamping in audio_mix_limit.
module audio_mix_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PUSH_GAP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH*32-1:0]  ch_data,
  input  logic [NUM_CH-1:0]     ch_valid,
  output logic [NUM_CH-1:0]     ch_ready,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [2:0]            atten_shift,
  audio_mix_scheduler_if.master out_if,
  output logic [15:0]           underrun_count,
  output logic                  busy
);

  localparam int ACC_W  = PCM_W + $clog2(NUM_CH) + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HOLD_W = (PUSH_GAP > 1) ? $clog2(PUSH_GAP) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CH - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(PUSH_GAP - 2);

  mix_state_t              state_r;
  mix_state_t              state_nxt_s;
  logic                    busy_r;
  logic [IDX_W-1:0]        idx_r;
  logic [HOLD_W-1:0]       hold_r;
  logic signed [ACC_W-1:0] acc_right_r;
  logic signed [ACC_W-1:0] acc_left_r;
  logic signed [ACC_W-1:0] add_right_s;
  logic signed [ACC_W-1:0] add_left_s;
  audio_frame_t            sel_frame_s;
  audio_frame_t            frame_r;
  logic [PCM_W-1:0]        mix_right_s;
  logic [PCM_W-1:0]        mix_left_s;
  logic [2*PCM_W-1:0]      out_data_r;
  logic                    toggle_r;
  logic [15:0]             underrun_r;
  logic                    take_s;
  logic                    miss_s;

  assign sel_frame_s = ch_data[{idx_r, 5'd0} +: 32];

  // Next-state logic; out_full only gates the start of a frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!out_if.out_full) state_nxt_s = GATHER;
        else                  state_nxt_s = IDLE;
      end
      GATHER: begin
        if (idx_r == LAST_IDX) state_nxt_s = SCALE;
        else                   state_nxt_s = GATHER;
      end
      SCALE: state_nxt_s = PUSH;
      PUSH: begin
        if (PUSH_GAP > 1) state_nxt_s = HOLD;
        else              state_nxt_s = IDLE;
      end
      HOLD: begin
        if (hold_r == LAST_HOLD) state_nxt_s = IDLE;
        else                     state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Ready pulse for the polled channel only, at most once per frame.
  always_comb begin
    ch_ready = {NUM_CH{1'b0}};
    if (state_r == GATHER) begin
      ch_ready[idx_r] = ch_enable[idx_r];
    end else begin
      ch_ready = {NUM_CH{1'b0}};
    end
  end

  // Classify the polled channel and select what it adds to the mix.
  always_comb begin
    take_s      = 1'b0;
    miss_s      = 1'b0;
    add_right_s = {ACC_W{1'b0}};
    add_left_s  = {ACC_W{1'b0}};
    if (state_r == GATHER) begin
      take_s = ch_enable[idx_r] & ch_valid[idx_r];
      miss_s = ch_enable[idx_r] & ~ch_valid[idx_r];
    end else begin
      take_s = 1'b0;
      miss_s = 1'b0;
    end
    if (take_s) begin
      add_right_s = ACC_W'(pcm_to_signed(sel_frame_s.r));
      add_left_s  = ACC_W'(pcm_to_signed(sel_frame_s.l));
    end else begin
      add_right_s = {ACC_W{1'b0}};
      add_left_s  = {ACC_W{1'b0}};
    end
  end

  audio_mix_limit #(.ACC_W(ACC_W)) u_limit_right (
    .acc   (acc_right_r),
    .shift (atten_shift),
    .pcm   (mix_right_s)
  );

  audio_mix_limit #(.ACC_W(ACC_W)) u_limit_left (
    .acc   (acc_left_r),
    .shift (atten_shift),
    .pcm   (mix_left_s)
  );

  // FSM state register; busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Frame datapath: accumulate, scale, push and hold-off counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r       <= {IDX_W{1'b0}};
      hold_r      <= {HOLD_W{1'b0}};
      acc_right_r <= {ACC_W{1'b0}};
      acc_left_r  <= {ACC_W{1'b0}};
      frame_r     <= {AUDIO_SILENCE, AUDIO_SILENCE};
      out_data_r  <= {AUDIO_SILENCE, AUDIO_SILENCE};
      toggle_r    <= 1'b0;
      underrun_r  <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          // Clearing here also covers a frame abandoned by reset.
          idx_r       <= {IDX_W{1'b0}};
          hold_r      <= {HOLD_W{1'b0}};
          acc_right_r <= {ACC_W{1'b0}};
          acc_left_r  <= {ACC_W{1'b0}};
        end
        GATHER: begin
          idx_r       <= idx_r + IDX_W'(1);
          acc_right_r <= acc_right_r + add_right_s;
          acc_left_r  <= acc_left_r + add_left_s;
          if (miss_s && (underrun_r != 16'hFFFF)) begin
            underrun_r <= underrun_r + 16'd1;
          end
        end
        SCALE: begin
          frame_r <= {mix_right_s, mix_left_s};
        end
        PUSH: begin
          out_data_r <= frame_r;
          toggle_r   <= ~toggle_r;
        end
        HOLD: begin
          hold_r <= hold_r + HOLD_W'(1);
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign out_if.out_data         = out_data_r;
  assign out_if.out_valid_toggle = toggle_r;
  assign underrun_count          = underrun_r;
  assign busy                    = busy_r;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Self-checking bench for audio_mix_scheduler (NUM_CH=4, PUSH_GAP=4).
// Honors AUDIO_MIX_SATURATE_EN in its reference model and expected tables.
module tb_audio_mix_scheduler;
  import audio_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int PUSH_GAP = 4;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   valid;
    logic [3:0]   enable;
    logic [2:0]   shift;
    logic [31:0]  expect_frame;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ch_data;
  logic [3:0]   ch_valid;
  logic [3:0]   ch_ready;
  logic [3:0]   ch_enable;
  logic [2:0]   atten_shift;
  logic [15:0]  underrun_count;
  logic         busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic exp_tog;
  int   exp_under;
  vec_t tbl [9];

  audio_mix_scheduler_if out_if();

  audio_mix_scheduler #(.NUM_CH(NUM_CH), .PUSH_GAP(PUSH_GAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .ch_data        (ch_data),
    .ch_valid       (ch_valid),
    .ch_ready       (ch_ready),
    .ch_enable      (ch_enable),
    .atten_shift    (atten_shift),
    .out_if         (out_if),
    .underrun_count (underrun_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One stereo side: signed sum, shift, limit, back to offset binary.
  function automatic logic [15:0] ref_side(input int sum, input logic [2:0] sh);
    int q;
    q = sum >>> sh;
`ifdef AUDIO_MIX_SATURATE_EN
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`endif
    return 16'(q + 32768);
  endfunction

  function automatic logic [31:0] ref_mix(input logic [127:0] d, input logic [3:0] v,
                                          input logic [3:0] en, input logic [2:0] sh);
    int sr;
    int sl;
    sr = 0;
    sl = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en[i] && v[i]) begin
        sr += int'(d[i*32+16 +: 16]) - 32768;
        sl += int'(d[i*32 +: 16]) - 32768;
      end
    end
    return {ref_side(sr, sh), ref_side(sl, sh)};
  endfunction

  task automatic wait_idle(input string name);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", out_if.out_data, 32'h8000_8000);
    chk("rst_toggle", 32'(out_if.out_valid_toggle), 32'd0);
    chk("rst_ready", 32'(ch_ready), 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_tog = 1'b0;
    exp_under = 0;
  endtask

  // Runs exactly one frame with inputs held, then checks everything.
  task automatic run_frame(input logic [127:0] d, input logic [3:0] v, input logic [3:0] en,
                           input logic [2:0] sh, input logic [31:0] exp, input string name);
    int   rdy_cnt [4];
    logic tog0;
    logic flipped;
    logic multi;
    logic [3:0] once;
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    @(negedge clk);
    ch_data     = d;
    ch_valid    = v;
    ch_enable   = en;
    atten_shift = sh;
    tog0        = out_if.out_valid_toggle;
    out_if.out_full = 1'b0;
    @(posedge clk);
    #1 out_if.out_full = 1'b1;
    flipped = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (ch_ready[i]) rdy_cnt[i]++;
      if (out_if.out_valid_toggle != tog0) flipped = 1'b1;
      if (flipped && !busy) break;
    end
    chk({name, "_done"}, {31'd0, flipped && !busy}, 32'd1);
    multi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      once[i] = (rdy_cnt[i] == 1);
      if (rdy_cnt[i] > 1) multi = 1'b1;
    end
    exp_tog = ~exp_tog;
    exp_under = exp_under + $countones(en & ~v);
    if (exp_under > 65535) exp_under = 65535;
    chk({name, "_data"}, out_if.out_data, exp);
    chk({name, "_toggle"}, 32'(out_if.out_valid_toggle), 32'(exp_tog));
    chk({name, "_ready"}, 32'({multi, once}), 32'({1'b0, en}));
    chk({name, "_underrun"}, 32'(underrun_count), 32'(exp_under));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [3:0]   v;
    logic [3:0]   en;
    logic [2:0]   sh;
    logic         prev;
    logic         any_rdy;
    int           flips;
    int           last_cyc;
    int           lat;
    logic         busy_seen;
    logic         tog_seen;

    reset = 1'b1;
    ch_data = 128'd0;
    ch_valid = 4'd0;
    ch_enable = 4'd0;
    atten_shift = 3'd0;
    out_if.out_full = 1'b0;

    tbl[0] = '{{96'd0, 32'hA000_6000}, 4'b0001, 4'b0001, 3'd0, 32'hA000_6000};
`ifdef AUDIO_MIX_SATURATE_EN
    tbl[1] = '{{4{32'hC000_C000}}, 4'b1111, 4'b1111, 3'd0, 32'hFFFF_FFFF};
    tbl[6] = '{{4{32'h0000_8000}}, 4'b1111, 4'b1111, 3'd0, 32'h0000_8000};
`else
    tbl[1] = '{{4{32'hC000_C000}}, 4'b1111, 4'b1111, 3'd0, 32'h8000_8000};
    tbl[6] = '{{4{32'h0000_8000}}, 4'b1111, 4'b1111, 3'd0, 32'h8000_8000};
`endif
    tbl[2] = '{{4{32'hC000_C000}}, 4'b1111, 4'b1111, 3'd2, 32'hC000_C000};
    tbl[3] = '{{4{32'h1234_5678}}, 4'b1111, 4'b0000, 3'd0, 32'h8000_8000};
    tbl[4] = '{{64'd0, 32'h9000_7000, 32'h9000_7000}, 4'b0011, 4'b0011, 3'd1, 32'h9000_7000};
    tbl[5] = '{{4{32'h0000_FFFF}}, 4'b1111, 4'b1111, 3'd2, 32'h0000_FFFF};
    tbl[7] = '{{32'd0, 32'h1234_FEDC, 64'd0}, 4'b0100, 4'b0100, 3'd7, 32'h7F24_80FD};
    tbl[8] = '{{4{32'h4000_C000}}, 4'b0010, 4'b1010, 3'd0, 32'h4000_C000};

    // Free-running silence frames with nothing enabled.
    do_reset();
    prev = out_if.out_valid_toggle;
    any_rdy = 1'b0;
    flips = 0;
    last_cyc = 0;
    for (int k = 0; k < 100 && flips < 4; k++) begin
      @(negedge clk);
      any_rdy = any_rdy | (|ch_ready);
      if (out_if.out_valid_toggle != prev) begin
        prev = out_if.out_valid_toggle;
        flips++;
        chk("t1_data", out_if.out_data, 32'h8000_8000);
        if (flips > 1) chk("t1_period", 32'(cyc - last_cyc), 32'd10);
        last_cyc = cyc;
      end
    end
    out_if.out_full = 1'b1;
    chk("t1_flips", 32'(flips), 32'd4);
    chk("t1_no_ready", 32'(any_rdy), 32'd0);
    exp_tog = exp_tog ^ flips[0];
    wait_idle("t1_idle");

    // Directed vector table.
    for (int t = 0; t < 9; t++) begin
      run_frame(tbl[t].data, tbl[t].valid, tbl[t].enable, tbl[t].shift,
                tbl[t].expect_frame, $sformatf("tbl%0d", t));
    end

    // Randomized frames against the reference model.
    for (int t = 0; t < 40; t++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      v  = (t % 3 == 0) ? 4'b1111 : 4'($urandom);
      en = 4'($urandom);
      sh = 3'($urandom_range(0, 7));
      run_frame(d, v, en, sh, ref_mix(d, v, en, sh), $sformatf("rnd%0d", t));
    end

    // Underruns on channel 1 for three frames, then valid.
    do_reset();
    d = {4{32'hA000_2000}};
    for (int t = 0; t < 3; t++) run_frame(d, 4'b0000, 4'b0010, 3'd0, 32'h8000_8000, "t4_miss");
    chk("t4_count3", 32'(underrun_count), 32'd3);
    run_frame(d, 4'b0010, 4'b0010, 3'd0, 32'hA000_2000, "t4_valid");
    chk("t4_count_hold", 32'(underrun_count), 32'd3);

    // Back-pressure: held off for 50 cycles, then measured start latency.
    d = {96'd0, 32'hA000_6000};
    ch_data = d;
    ch_valid = 4'b0001;
    ch_enable = 4'b0001;
    atten_shift = 3'd0;
    prev = out_if.out_valid_toggle;
    busy_seen = 1'b0;
    tog_seen = 1'b0;
    any_rdy = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
      tog_seen = tog_seen | (out_if.out_valid_toggle != prev);
      any_rdy = any_rdy | (|ch_ready);
    end
    chk("t5_no_busy", 32'(busy_seen), 32'd0);
    chk("t5_no_toggle", 32'(tog_seen), 32'd0);
    chk("t5_no_ready", 32'(any_rdy), 32'd0);
    out_if.out_full = 1'b0;
    @(posedge clk);
    #1 out_if.out_full = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_if.out_valid_toggle != prev) break;
    end
    chk("t5_latency", 32'(lat), 32'd6);
    exp_tog = ~exp_tog;
    chk("t5_data", out_if.out_data, ref_mix(d, 4'b0001, 4'b0001, 3'd0));
    wait_idle("t5_idle");

    // Reset in the middle of GATHER.
    @(negedge clk);
    d = {$urandom, $urandom, $urandom, $urandom};
    ch_data = d;
    ch_valid = 4'b1111;
    ch_enable = 4'b1111;
    atten_shift = 3'd1;
    out_if.out_full = 1'b0;
    @(posedge clk);
    #1 out_if.out_full = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6_idx2_ready", 32'(ch_ready), 32'h4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_data", out_if.out_data, 32'h8000_8000);
    chk("t6_rst_toggle", 32'(out_if.out_valid_toggle), 32'd0);
    chk("t6_rst_ready", 32'(ch_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_underrun", 32'(underrun_count), 32'd0);
    reset = 1'b0;
    exp_tog = 1'b0;
    exp_under = 0;
    repeat (3) @(negedge clk);
    chk("t6_no_toggle", 32'(out_if.out_valid_toggle), 32'd0);
    out_if.out_full = 1'b0;
    @(posedge clk);
    #1 out_if.out_full = 1'b1;
    chk("t6_first_idx", 32'(ch_ready), 32'h1);
    wait_idle("t6_idle");
    chk("t6_data", out_if.out_data, ref_mix(d, 4'b1111, 4'b1111, 3'd1));
    chk("t6_toggle", 32'(out_if.out_valid_toggle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
